// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Drives PC next-state, imem req/ack, 2-entry inst queue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        pc_ce,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [1:0]  count_q;
  logic        head_q;
  logic [31:0] qpc_q   [2];
  logic [31:0] qinst_q [2];

  logic        pop;
  logic        push;
  logic        tail;
  logic [1:0]  occ;
  logic [31:0] addr_inc;

  // Wraps modulo 2^32, so FFFFFFFC + 4 gives 0.
  assign addr_inc = addr_q + 32'd4;
  assign pop      = inst_valid & inst_ready;
  assign push     = (state_q == REQ) & imem_ack & ~redirect;
  assign tail     = head_q ^ count_q[0];
  assign occ      = count_q + {1'b0, push} - {1'b0, pop};

  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = addr_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst       = inst_valid ? qinst_q[head_q] : '0;
  assign inst_pc    = inst_valid ? qpc_q[head_q] : '0;

  // PC register next value: reset, then redirect, then ack increment.
  always_comb begin
    pc_ce = 1'b0;
    pc_d  = pc_q;
    if (!rst) begin
      pc_ce = 1'b1;
      pc_d  = RESET_PC;
    end else if (redirect) begin
      pc_ce = 1'b1;
      pc_d  = redirect_pc;
    end else if (push) begin
      pc_ce = 1'b1;
      pc_d  = addr_inc;
    end
  end

  // Request FSM; a slot is reserved at issue so a push never overflows.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!redirect && count_q < 2'd2) begin
            state_q <= REQ;
            addr_q  <= pc_q;
          end
        end
        REQ: begin
          if (redirect) begin
            state_q <= imem_ack ? IDLE : DROP;
          end else if (imem_ack) begin
            if (occ < 2'd2) begin
              addr_q <= addr_inc;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-entry FIFO; redirect flushes and wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      head_q     <= 1'b0;
      qpc_q[0]   <= '0;
      qpc_q[1]   <= '0;
      qinst_q[0] <= '0;
      qinst_q[1] <= '0;
    end else if (redirect) begin
      count_q <= '0;
      head_q  <= 1'b0;
    end else begin
      count_q <= occ;
      if (pop) begin
        head_q <= ~head_q;
      end
      if (push) begin
        qpc_q[tail]   <= addr_q;
        qinst_q[tail] <= imem_rdata;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the CPU pipeline, sitting directly upstream of the 32-bit PC register. It computes the PC register's next value and load enable and issues word fetches to instruction memory over a req/ack handshake. Fetched words go into a 2-entry queue that feeds decode over valid/ready. Branch/jump redirects from execute flush the queue and squash any in-flight fetch.

## Interface
- RESET_PC, 32'h00000000, PC value loaded into the PC register during reset.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- pc_q  in  32  current PC, from PC register output
- pc_d  out  32  next PC, to PC register D
- pc_ce  out  1  PC register load enable
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  fetch address, registered, stable while imem_req=1
- imem_ack  in  1  memory completes request this cycle; may assert in the first req cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- redirect  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  32  target PC, valid with redirect
- inst_valid  out  1  queue head valid
- inst  out  32  queue head instruction
- inst_pc  out  32  PC of queue head
- inst_ready  in  1  decode accepts head; pop when inst_valid & inst_ready

## Operation
- State machine: IDLE (no request), REQ (imem_req=1, awaiting ack), DROP (imem_req=1, awaiting ack, result discarded). imem_req = (state != IDLE).
- Queue: 2 entries of {pc, inst}, FIFO order. count 0..2. inst_valid = (count != 0). inst/inst_pc are the head entry, 0 when empty.
- IDLE -> REQ when count < 2 and redirect=0. Latch req_addr <= pc_q.
- In REQ, on ack with redirect=0:
  - Push {req_addr, imem_rdata}.
  - pc_ce=1, pc_d = req_addr + 4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
  - If the occupancy after this cycle's push/pop is < 2, stay in REQ with req_addr <= req_addr + 4 (back-to-back). Otherwise go to IDLE.
- REQ without ack: hold req_addr. pc_ce=0.
- Redirect, in any state:
  - Queue cleared (count <= 0); a same-cycle pop or push is ignored.
  - pc_ce=1, pc_d = redirect_pc. This overrides the ack increment.
  - REQ without ack -> DROP. REQ with ack -> IDLE, data discarded. IDLE stays IDLE. DROP stays DROP.
- DROP on ack -> IDLE, data discarded, no PC update unless redirect is also asserted.
- Space is reserved at issue: at most one request outstanding, and issue requires count < 2. A push therefore never finds the queue full.
- pc_ce=0 and pc_d=pc_q in all cases not listed above.

## Timing
- While rst=0, every cycle:
  - Combinational: pc_ce=1, pc_d=RESET_PC.
  - Registered next edge: state=IDLE, count=0, imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0.
- Reset mid-request abandons the request. The memory is reset alongside and must not deliver a stale ack.
- Cycle 0 = first cycle with rst=1: IDLE, pc_q=RESET_PC, so imem_req=1 with imem_addr=RESET_PC in cycle 1.
- A zero-wait ack in cycle 1 gives inst_valid=1 in cycle 2. Fetch-to-queue latency is 1 cycle after ack.
- Zero-wait memory with inst_ready=1: sustained 1 instruction/cycle, imem_req held continuously.
- Redirect in cycle N:
  - pc_q = redirect_pc in N+1; inst_valid=0 in N+1.
  - New request at redirect_pc starts in N+2 if no fetch was outstanding.
  - Otherwise it starts the cycle after the DROP ack.
- Queue full with inst_ready=0: imem_req=0, PC holds.

## Test plan
- Reset/startup: RESET_PC=32'h00400000, hold rst=0 for 3 cycles, zero-wait memory returning addr^32'hFFFFFFFF -> pc_ce=1 during reset; imem_addr=32'h00400000 in cycle 1; inst_pc/inst = 00400000/FFBFFFFF in cycle 2.
- Streaming: zero-wait memory, inst_ready=1 -> inst_pc 00400000, 00400004, 00400008, ... one per cycle; pc_q tracks inst_pc+4.
- Backpressure: inst_ready=0 from cycle 2 -> count reaches 2, imem_req=0, PC frozen at 00400008. Release ready -> order preserved, no duplicated or lost PCs.
- Redirect with in-flight fetch: 3-cycle ack latency, redirect to 32'h00001000 in the 2nd wait cycle -> stale ack discarded, queue empty, next imem_addr=00001000, first delivered inst_pc=00001000.
- Redirect coincident with ack and pop: all three asserted together -> queue empty next cycle, pc_q=redirect_pc, acked word never appears.
- Wrap and mid-operation reset: redirect to 32'hFFFFFFFC -> next fetch address 0. Assert rst=0 while in REQ -> all outputs at reset values next cycle.
